coin_input_conditioner: RTL

Front end of the vending-machine datapath. It takes the raw, asynchronous nickel and dime sensor/button lines and synchronises and debounces them. It then delivers clean one-cycle coin codes to the coin-accumulating Moore FSM that sits directly downstream. Coins are held back while the downstream FSM signals a vend, so that no coin is lost in the vend cycle.

---
 rtl/coin_pkg.sv | 19 +
 rtl/coin_debounce.sv | 101 ++++++++++
 rtl/coin_input_conditioner.sv | 87 ++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// Shared definitions for the vending-machine coin path: coin codes seen by the
// downstream accumulating FSM, the debounce state type and default timing.
package coin_pkg;

    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_NICKEL = 2'b01;
    localparam logic [1:0] COIN_DIME   = 2'b10;

    // 1 ms of stable input at 50 MHz
    localparam int DEBOUNCE_CYCLES_DFLT = 50000;

    typedef enum logic [1:0] {
        DEB_IDLE      = 2'd0,
        DEB_ARMING    = 2'd1,
        DEB_PRESSED   = 2'd2,
        DEB_RELEASING = 2'd3
    } deb_state_t;

endpackage

// File: rtl/coin_debounce.sv
// Per-channel front end: 2-FF synchroniser followed by a debounce FSM that
// emits a one-cycle press event once the input has been stably high for
// DEBOUNCE_CYCLES synchronised samples.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | released and stable; counter cleared
//   ARMING     | input high, counting stable high samples toward a press
//   PRESSED    | press accepted; waiting for the input to drop
//   RELEASING  | input low, counting stable low samples toward IDLE
module coin_debounce
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic            sync_meta;
    logic            sync;
    deb_state_t      state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_inc;

    // Saturating increment; the FSM leaves the counting state when it hits max.
    assign count_inc = (count == CNT_MAX) ? count : count + CNT_ONE;

    // Decoded from registered state so the pending flag is set on the same
    // edge that the FSM enters PRESSED.
    assign press = (state == DEB_ARMING) && sync && (count_inc == CNT_MAX);

    // Two-stage synchroniser for the asynchronous sensor line.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
        end
    end

    // Debounce FSM and its stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DEB_IDLE;
            count <= '0;
        end else begin
            case (state)
                DEB_IDLE: begin
                    count <= '0;
                    if (sync) begin
                        state <= DEB_ARMING;
                        count <= CNT_ONE;
                    end
                end
                DEB_ARMING: begin
                    if (!sync) begin
                        state <= DEB_IDLE;
                        count <= '0;
                    end else if (count_inc == CNT_MAX) begin
                        state <= DEB_PRESSED;
                        count <= '0;
                    end else begin
                        count <= count_inc;
                    end
                end
                DEB_PRESSED: begin
                    count <= '0;
                    if (!sync) begin
                        state <= DEB_RELEASING;
                        count <= CNT_ONE;
                    end
                end
                DEB_RELEASING: begin
                    if (sync) begin
                        state <= DEB_PRESSED;
                        count <= '0;
                    end else if (count_inc == CNT_MAX) begin
                        state <= DEB_IDLE;
                        count <= '0;
                    end else begin
                        count <= count_inc;
                    end
                end
                default: begin
                    state <= DEB_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin input conditioner: debounced nickel/dime presses are held in pending
// flags and issued as one-cycle coin codes, nickel first, never back to back
// and never while the downstream FSM is vending.
// Optional build macro COIN_COUNT_EN adds saturating issued-coin counters.
module coin_input_conditioner
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nickel_raw,
    input  logic       dime_raw,
    input  logic       vend_busy,
`ifdef COIN_COUNT_EN
    output logic [7:0] nickel_count,
    output logic [7:0] dime_count,
`endif
    output logic [1:0] coin,
    output logic       coin_overrun
);

    logic press_nickel;
    logic press_dime;
    logic pend_nickel;
    logic pend_dime;
    logic slot_free;
    logic issue_nickel;
    logic issue_dime;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_nickel (
        .clk   (clk),
        .reset (reset),
        .raw   (nickel_raw),
        .press (press_nickel)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dime (
        .clk   (clk),
        .reset (reset),
        .raw   (dime_raw),
        .press (press_dime)
    );

    // A slot is free when the downstream FSM is idle and the previous cycle
    // issued nothing, which guarantees a 00 gap after every pulse.
    assign slot_free    = !vend_busy && (coin == COIN_NONE);
    assign issue_nickel = slot_free && pend_nickel;
    assign issue_dime   = slot_free && pend_dime && !pend_nickel;

    // Pending flags, coin register and overrun pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_nickel  <= 1'b0;
            pend_dime    <= 1'b0;
            coin         <= COIN_NONE;
            coin_overrun <= 1'b0;
        end else begin
            if (issue_nickel)    coin <= COIN_NICKEL;
            else if (issue_dime) coin <= COIN_DIME;
            else                 coin <= COIN_NONE;

            if (press_nickel)      pend_nickel <= 1'b1;
            else if (issue_nickel) pend_nickel <= 1'b0;

            if (press_dime)      pend_dime <= 1'b1;
            else if (issue_dime) pend_dime <= 1'b0;

            coin_overrun <= (press_nickel && pend_nickel && !issue_nickel) ||
                            (press_dime   && pend_dime   && !issue_dime);
        end
    end

`ifdef COIN_COUNT_EN
    // Saturating counts of coins actually issued downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            nickel_count <= 8'd0;
            dime_count   <= 8'd0;
        end else begin
            if (issue_nickel && nickel_count != 8'hFF) nickel_count <= nickel_count + 8'd1;
            if (issue_dime   && dime_count   != 8'hFF) dime_count   <= dime_count + 8'd1;
        end
    end
`endif

endmodule
